// File: rtl/pcie_cq_desc_parser_if.sv
// AXI4-Stream bundle for the CQ path, with master/slave views.
interface pcie_cq_desc_parser_if #(
   parameter int DW = 512,
   parameter int UW = 229
);
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic            tvalid;
   logic            tready;
   logic            tlast;
   logic [UW-1:0]   tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/pcie_cq_desc_parser.sv
// CQ skid-buffered pass-through with SOP descriptor capture onto a valid/ready channel.
// Optional length check compiled in with `define CQ_PARSER_LEN_CHECK_EN.
module pcie_cq_desc_parser #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_TUSER_WIDTH = 229
) (
   input  logic                        clk,
   input  logic                        rst,
   pcie_cq_desc_parser_if.slave        s_axis,
   pcie_cq_desc_parser_if.master       m_axis,
   output logic                        desc_valid,
   input  logic                        desc_ready,
   output logic [63:0]                 desc_addr,
   output logic [1:0]                  desc_at,
   output logic [10:0]                 desc_dwc,
   output logic [3:0]                  desc_type,
   output logic [15:0]                 desc_req_id,
   output logic [7:0]                  desc_tag,
   output logic [7:0]                  desc_func,
   output logic [2:0]                  desc_bar_id,
   output logic [5:0]                  desc_bar_aperture,
   output logic [15:0]                 pkt_cnt,
   output logic [7:0]                  len_err_cnt,
   output logic                        len_err
);
   localparam int KW = AXIS_DATA_WIDTH / 8;
   localparam int BW = AXIS_DATA_WIDTH + KW + 1 + AXIS_TUSER_WIDTH;

   typedef enum logic {IDLE, IN_PKT} state_t;

   typedef struct packed {
      logic [5:0]  bar_ap;
      logic [2:0]  bar_id;
      logic [7:0]  func;
      logic [7:0]  tag;
      logic [15:0] req_id;
      logic [3:0]  typ;
      logic [10:0] dwc;
      logic [1:0]  at;
      logic [61:0] addr;
   } desc_t;

   logic [BW-1:0] main_q, main_d, skid_q, skid_d, in_beat;
   logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic          tready_q, tready_d;
   state_t        state_q, state_d;
   desc_t         desc_q, desc_d;
   logic          desc_valid_q, desc_valid_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;
   logic          is_sop, sop_stall, acc, cap;

   assign in_beat   = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};
   assign is_sop    = |s_axis.tuser[81:80];
   assign sop_stall = s_axis.tvalid && is_sop && (state_q == IDLE) && desc_valid_q && !desc_ready;
   assign acc       = s_axis.tvalid && tready_q && !sop_stall;
   assign cap       = acc && is_sop && (state_q == IDLE);

   // Skid register only fills while the main register is stalled; it drains first.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!main_vld_q || m_axis.tready) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = acc;
            if (acc) main_d = in_beat;
         end
      end else if (acc) begin
         skid_d     = in_beat;
         skid_vld_d = 1'b1;
      end
      tready_d = !skid_vld_d;
   end

   always_comb begin
      state_d = state_q;
      if (acc) begin
         case (state_q)
            IDLE:    if (is_sop && !s_axis.tlast) state_d = IN_PKT;
            IN_PKT:  if (s_axis.tlast) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A capture in the same cycle as a consume keeps the channel full.
   always_comb begin
      desc_d       = desc_q;
      desc_valid_d = desc_valid_q;
      pkt_cnt_d    = pkt_cnt_q;
      if (desc_valid_q && desc_ready) desc_valid_d = 1'b0;
      if (cap) begin
         desc_d.addr   = s_axis.tdata[63:2];
         desc_d.at     = s_axis.tdata[1:0];
         desc_d.dwc    = s_axis.tdata[74:64];
         desc_d.typ    = s_axis.tdata[78:75];
         desc_d.req_id = s_axis.tdata[95:80];
         desc_d.tag    = s_axis.tdata[103:96];
         desc_d.func   = s_axis.tdata[111:104];
         desc_d.bar_id = s_axis.tdata[114:112];
         desc_d.bar_ap = s_axis.tdata[120:115];
         desc_valid_d  = 1'b1;
         pkt_cnt_d     = pkt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         main_vld_q   <= 1'b0;
         skid_q       <= '0;
         skid_vld_q   <= 1'b0;
         tready_q     <= 1'b0;
         state_q      <= IDLE;
         desc_q       <= '0;
         desc_valid_q <= 1'b0;
         pkt_cnt_q    <= '0;
      end else begin
         main_q       <= main_d;
         main_vld_q   <= main_vld_d;
         skid_q       <= skid_d;
         skid_vld_q   <= skid_vld_d;
         tready_q     <= tready_d;
         state_q      <= state_d;
         desc_q       <= desc_d;
         desc_valid_q <= desc_valid_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

`ifdef CQ_PARSER_LEN_CHECK_EN
   logic [6:0]  exp_q, exp_d, cnt_q, cnt_d, exp_now, cnt_inc;
   logic [11:0] dw_full, dw_sum;
   logic [7:0]  lec_q, lec_d;
   logic        len_err_q, len_err_d, payload;

   // dwc 0 encodes 1024 DW; beats = 1 + ceil((dw-12)/16) = 1 + ((dw+3)>>4) above 12 DW.
   assign dw_full = (s_axis.tdata[74:64] == 11'd0) ? 12'd1024 : {1'b0, s_axis.tdata[74:64]};
   assign dw_sum  = dw_full + 12'd3;
   assign payload = s_axis.tdata[78:75] inside {4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
   assign exp_now = (payload && dw_full > 12'd12) ? 7'd1 + dw_sum[10:4] : 7'd1;
   assign cnt_inc = cnt_q + 7'd1;

   always_comb begin
      exp_d     = exp_q;
      cnt_d     = cnt_q;
      len_err_d = 1'b0;
      if (cap) begin
         cnt_d     = 7'd1;
         exp_d     = exp_now;
         len_err_d = s_axis.tlast && (exp_now != 7'd1);
      end else if (acc && state_q == IN_PKT) begin
         cnt_d     = cnt_inc;
         len_err_d = s_axis.tlast && (cnt_inc != exp_q);
      end
      lec_d = (len_err_d && lec_q != 8'hFF) ? lec_q + 8'd1 : lec_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q     <= '0;
         cnt_q     <= '0;
         lec_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         exp_q     <= exp_d;
         cnt_q     <= cnt_d;
         lec_q     <= lec_d;
         len_err_q <= len_err_d;
      end
   end

   assign len_err     = len_err_q;
   assign len_err_cnt = lec_q;
`else
   assign len_err     = 1'b0;
   assign len_err_cnt = 8'd0;
`endif

   assign s_axis.tready = tready_q && !sop_stall;
   assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser} = main_q;
   assign m_axis.tvalid = main_vld_q;

   assign desc_valid        = desc_valid_q;
   assign desc_addr         = {desc_q.addr, 2'b00};
   assign desc_at           = desc_q.at;
   assign desc_dwc          = desc_q.dwc;
   assign desc_type         = desc_q.typ;
   assign desc_req_id       = desc_q.req_id;
   assign desc_tag          = desc_q.tag;
   assign desc_func         = desc_q.func;
   assign desc_bar_id       = desc_q.bar_id;
   assign desc_bar_aperture = desc_q.bar_ap;
   assign pkt_cnt           = pkt_cnt_q;
endmodule

// File: tb/tb_pcie_cq_desc_parser.sv
// Scoreboard bench for pcie_cq_desc_parser: beat and descriptor queues filled on input accept.
module tb_pcie_cq_desc_parser;
   localparam int DW = 512;
   localparam int UW = 229;
`ifdef CQ_PARSER_LEN_CHECK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pcie_cq_desc_parser_if #(.DW(DW), .UW(UW)) s_if ();
   pcie_cq_desc_parser_if #(.DW(DW), .UW(UW)) m_if ();

   logic        desc_valid, desc_ready, len_err;
   logic [63:0] desc_addr;
   logic [1:0]  desc_at;
   logic [10:0] desc_dwc;
   logic [3:0]  desc_type;
   logic [15:0] desc_req_id, pkt_cnt;
   logic [7:0]  desc_tag, desc_func, len_err_cnt;
   logic [2:0]  desc_bar_id;
   logic [5:0]  desc_bar_aperture;

   pcie_cq_desc_parser dut (
      .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
      .desc_at(desc_at), .desc_dwc(desc_dwc), .desc_type(desc_type),
      .desc_req_id(desc_req_id), .desc_tag(desc_tag), .desc_func(desc_func),
      .desc_bar_id(desc_bar_id), .desc_bar_aperture(desc_bar_aperture),
      .pkt_cnt(pkt_cnt), .len_err_cnt(len_err_cnt), .len_err(len_err)
   );

   typedef struct packed {
      logic [DW-1:0]   d;
      logic [DW/8-1:0] k;
      logic            l;
      logic [UW-1:0]   u;
   } beat_t;

   beat_t            bq[$];
   logic [126:0]     dq[$];
   int               total = 0;
   int               bad = 0;
   int               lerr_pulses = 0;
   int               rdy_mode = 0;
   bit               in_pkt = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [126:0] exd(input logic [DW-1:0] d);
      return {{d[63:2], 2'b00}, d[1:0], d[74:64], d[78:75], d[95:80], d[103:96],
              d[111:104], d[114:112], d[120:115]};
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DW-1:0] mk_hdr(input logic [3:0] typ, input logic [10:0] dwc,
                                            input logic [63:0] addr, input logic [7:0] tag);
      logic [DW-1:0] d;
      d = rnd_data();
      d[63:0]    = addr;
      d[74:64]   = dwc;
      d[78:75]   = typ;
      d[103:96]  = tag;
      return d;
   endfunction

   // Monitor: consume outputs first, then record newly accepted stimulus.
   initial forever begin
      beat_t        b;
      logic [126:0] de;
      @(negedge clk);
      if (!rst) begin
         if (m_if.tvalid && m_if.tready) begin
            if (bq.size() == 0) chk("extra_beat", 1, 0);
            else begin
               b = bq.pop_front();
               chk("tdata", m_if.tdata, b.d);
               chk("tside", {m_if.tkeep, m_if.tlast, m_if.tuser}, {b.k, b.l, b.u});
            end
         end
         if (desc_valid && desc_ready) begin
            if (dq.size() == 0) chk("extra_desc", 1, 0);
            else begin
               de = dq.pop_front();
               chk("desc", {desc_addr, desc_at, desc_dwc, desc_type, desc_req_id, desc_tag,
                            desc_func, desc_bar_id, desc_bar_aperture}, de);
            end
         end
         if (s_if.tvalid && s_if.tready) begin
            bq.push_back('{s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser});
            if (!in_pkt) begin
               if (|s_if.tuser[81:80]) begin
                  dq.push_back(exd(s_if.tdata));
                  in_pkt = !s_if.tlast;
               end
            end else if (s_if.tlast) in_pkt = 0;
         end
         if (len_err) lerr_pulses++;
      end
   end

   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ~m_if.tready;
            default: m_if.tready = 1'b0;
         endcase
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic lst, input logic [1:0] sop);
      logic          acc;
      int            n;
      logic [UW-1:0] u;
      acc = 1'b0;
      n = 0;
      for (int i = 0; i < UW; i++) u[i] = 1'($urandom_range(0, 1));
      u[81:80] = sop;
      s_if.tdata  = d;
      s_if.tkeep  = {$urandom, $urandom};
      s_if.tlast  = lst;
      s_if.tuser  = u;
      s_if.tvalid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = s_if.tready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) chk("send_timeout", 0, 1);
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((bq.size() != 0 || dq.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", bq.size() + dq.size(), 0);
   endtask

   task automatic reset_flush();
      rst = 1'b1;
      #1;
      bq.delete();
      dq.delete();
      in_pkt = 0;
   endtask

   initial begin
      int p0;
      logic [DW-1:0] h;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = '0;
      desc_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mvalid", m_if.tvalid, 0);
      chk("rst_mdata", m_if.tdata, 0);
      chk("rst_sready", s_if.tready, 0);
      chk("rst_desc", {desc_valid, desc_addr, desc_tag, desc_type}, 0);
      chk("rst_cnts", {pkt_cnt, len_err_cnt, len_err}, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("sready_up", s_if.tready, 1);

      // single-beat memory read
      send(mk_hdr(4'b0000, 11'd1, 64'h1000, 8'h5A), 1'b1, 2'b01);
      chk("t1_lat", m_if.tvalid, 1);
      chk("t1_dvalid", desc_valid, 1);
      chk("t1_addr", desc_addr, 64'h1000);
      chk("t1_tag", desc_tag, 8'h5A);
      chk("t1_type", desc_type, 0);
      chk("t1_pkt", pkt_cnt, 1);
      drain();

      // dwc 28 write, two beats, toggling backpressure
      rdy_mode = 1;
      p0 = lerr_pulses;
      send(mk_hdr(4'b0001, 11'd28, 64'h2000, 8'h01), 1'b0, 2'b01);
      send(rnd_data(), 1'b1, 2'b00);
      drain();
      rdy_mode = 0;
      chk("t2_lerr", lerr_pulses - p0, 0);
      chk("t2_lcnt", len_err_cnt, 0);

      // dwc 29 write sent short
      p0 = lerr_pulses;
      send(mk_hdr(4'b0001, 11'd29, 64'h3000, 8'h02), 1'b0, 2'b10);
      send(rnd_data(), 1'b1, 2'b00);
      chk("t3_pulse", len_err, EN);
      drain();
      chk("t3_lerr", lerr_pulses - p0, EN ? 1 : 0);
      chk("t3_lcnt", len_err_cnt, EN ? 1 : 0);

      // descriptor backpressure stalls the second SOP
      desc_ready = 1'b0;
      send(mk_hdr(4'b0000, 11'd1, 64'h4000, 8'hA1), 1'b1, 2'b01);
      h = mk_hdr(4'b0000, 11'd2, 64'h5008, 8'hB2);
      fork
         send(h, 1'b1, 2'b11);
         begin
            repeat (3) begin @(posedge clk); #1; end
            chk("t4_stall", s_if.tready, 0);
            chk("t4_held", desc_tag, 8'hA1);
            desc_ready = 1'b1;
            @(posedge clk); #1;
            desc_ready = 1'b0;
         end
      join
      chk("t4_dvalid", desc_valid, 1);
      chk("t4_tag", desc_tag, 8'hB2);
      chk("t4_addr", desc_addr, 64'h5008);
      desc_ready = 1'b1;
      drain();
      chk("t4_pkt", pkt_cnt, 5);

      // reset in the middle of a 3-beat write
      rdy_mode = 2;
      @(posedge clk); #1;
      send(mk_hdr(4'b0001, 11'd40, 64'h6000, 8'hC3), 1'b0, 2'b01);
      chk("t5_buffered", m_if.tvalid, 1);
      #2;
      reset_flush();
      chk("t5_mvalid", m_if.tvalid, 0);
      chk("t5_mdata", m_if.tdata, 0);
      chk("t5_sready", s_if.tready, 0);
      chk("t5_desc", {desc_valid, desc_tag, desc_addr}, 0);
      chk("t5_cnt", pkt_cnt, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      rdy_mode = 0;
      @(posedge clk); #1;
      p0 = lerr_pulses;
      send(rnd_data() & ~(512'd3 << 80), 1'b0, 2'b00);
      send(rnd_data(), 1'b1, 2'b00);
      drain();
      chk("t5_orphan_pkt", pkt_cnt, 0);
      chk("t5_orphan_desc", desc_valid, 0);
      chk("t5_orphan_lerr", lerr_pulses - p0, 0);
      send(mk_hdr(4'b0000, 11'd1, 64'h7000, 8'h77), 1'b1, 2'b01);
      chk("t5_tag", desc_tag, 8'h77);
      chk("t5_pkt", pkt_cnt, 1);
      drain();

      // saturation of the mismatch counter
      reset_flush();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++)
         send(mk_hdr(4'b0001, 11'd29, 64'h8000 + 64'(i * 4), 8'(i)), 1'b1, 2'b01);
      drain();
      chk("t6_pkt", pkt_cnt, 300);
      chk("t6_lcnt", len_err_cnt, EN ? 8'hFF : 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
